godai_mem_arbiter: RTL

//  Shares one single-port memory between the core's instruction and data interfaces.

---
 rtl/godai_pkg.sv | 10 +
 rtl/godai_arb_owner_fifo.sv | 56 +++++
 rtl/godai_mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/godai_pkg.sv
// Shared constants for the godai memory arbiter: requester ids and the fixed
// attributes of instruction fetches on the shared port.
package godai_pkg;

    localparam logic       OWNER_INSTR = 1'b0;
    localparam logic       OWNER_DATA  = 1'b1;
    localparam logic [3:0] BE_ALL      = 4'hF;
    localparam logic       WE_RD       = 1'b0;

endpackage

// File: rtl/godai_arb_owner_fifo.sv
// One-bit-wide owner FIFO: remembers which requester owns each granted but
// unanswered transaction so responses can be routed back in order.
module godai_arb_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0] slots;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = slots[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: slot storage is not reset; slots are only read once count marks them valid.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= din;
    end

endmodule

// File: rtl/godai_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the instruction and
// data req/gnt/rvalid interfaces, with address-phase locking and in-order responses.
module godai_mem_arbiter
    import godai_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i
);

    logic last_gnt;
    logic lock_valid;
    logic lock_id;
    logic lock_hold;
    logic winner;
    logic handshake;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;
    logic rvalid_stray;
    logic resp_pop;

    // A stalled address phase keeps the port as long as its owner keeps requesting.
    assign lock_hold = lock_valid & ((lock_id == OWNER_DATA) ? data_req_i : instr_req_i);

    // NOTE: every output of this block is assigned first, so no latch is inferred.
    always_comb begin
        winner = OWNER_INSTR;
        if (lock_hold)                      winner = lock_id;
        else if (instr_req_i && data_req_i) winner = ~last_gnt;
        else if (data_req_i)                winner = OWNER_DATA;
    end

    assign mem_req_o   = rst_n & (instr_req_i | data_req_i) & ~fifo_full;
    assign handshake   = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = handshake & (winner == OWNER_INSTR);
    assign data_gnt_o  = handshake & (winner == OWNER_DATA);

    always_comb begin
        mem_we_o    = WE_RD;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (winner == OWNER_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = BE_ALL;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt   <= OWNER_INSTR;
            lock_valid <= 1'b0;
            lock_id    <= OWNER_INSTR;
        end else if (handshake) begin
            last_gnt   <= winner;
            lock_valid <= 1'b0;
        end else if (mem_req_o) begin
            lock_valid <= 1'b1;
            lock_id    <= winner;
        end
    end

    // Responses with no recorded owner are protocol violations and are dropped.
    assign rvalid_stray = rst_n & mem_rvalid_i & fifo_empty;
    assign resp_pop     = rst_n & mem_rvalid_i & ~rvalid_stray;

    assign instr_rvalid_o = resp_pop & (fifo_head == OWNER_INSTR);
    assign data_rvalid_o  = resp_pop & (fifo_head == OWNER_DATA);
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign instr_rdata_o  = {DATA_WIDTH{rst_n}} & mem_rdata_i;
    assign data_rdata_o   = {DATA_WIDTH{rst_n}} & mem_rdata_i;

    godai_arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (handshake),
        .pop   (resp_pop),
        .din   (winner),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef GODAI_ARB_ASSERT
    always_ff @(posedge clk) begin
        if (rst_n) assert (!rvalid_stray) else $error("mem_rvalid_i with no outstanding transaction");
    end
`endif

endmodule
